// File: rtl/cc_wb_load_ctrl_if.sv
// Writeback/load controller bus.
// Groups the request handshake, the writeback sources and the load-enable
// outputs of cc_wb_load_ctrl.
//   master : microsequencer / ALU / memory side (drives requests and data)
//   slave  : the controller itself
// Signals:
//   CC_WB_LOAD_Start_In          request valid (sampled only while Ready_Out=1)
//   CC_WB_LOAD_RD_In             source select at start: 1=memory, 0=ALU
//   CC_WB_LOAD_ALU_data_InBus    ALU result
//   CC_WB_LOAD_Address_InBus     destination register address
//   CC_WB_LOAD_MemReady_In       memory data valid this cycle
//   CC_WB_LOAD_Memory_data_InBus memory read data
//   CC_WB_LOAD_ErrorClear_In     synchronous clear of the sticky timeout flag
//   CC_WB_LOAD_data_OutBus       registered writeback data
//   CC_WB_LOAD_Load_OutBus       active-low one-cold register load enables
//   CC_WB_LOAD_Ready_Out         request can be accepted this cycle
//   CC_WB_LOAD_Timeout_Out       sticky memory-timeout flag
interface cc_wb_load_ctrl_if #(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DATAWIDTH_MIR_DIRECTION = 6,
    parameter int NUM_REGS                = 14
);
    logic                               CC_WB_LOAD_Start_In;
    logic                               CC_WB_LOAD_RD_In;
    logic [DATAWIDTH_BUS-1:0]           CC_WB_LOAD_ALU_data_InBus;
    logic [DATAWIDTH_MIR_DIRECTION-1:0] CC_WB_LOAD_Address_InBus;
    logic                               CC_WB_LOAD_MemReady_In;
    logic [DATAWIDTH_BUS-1:0]           CC_WB_LOAD_Memory_data_InBus;
    logic                               CC_WB_LOAD_ErrorClear_In;
    logic [DATAWIDTH_BUS-1:0]           CC_WB_LOAD_data_OutBus;
    logic [NUM_REGS-1:0]                CC_WB_LOAD_Load_OutBus;
    logic                               CC_WB_LOAD_Ready_Out;
    logic                               CC_WB_LOAD_Timeout_Out;

    modport master (
        output CC_WB_LOAD_Start_In, CC_WB_LOAD_RD_In, CC_WB_LOAD_ALU_data_InBus,
               CC_WB_LOAD_Address_InBus, CC_WB_LOAD_MemReady_In,
               CC_WB_LOAD_Memory_data_InBus, CC_WB_LOAD_ErrorClear_In,
        input  CC_WB_LOAD_data_OutBus, CC_WB_LOAD_Load_OutBus,
               CC_WB_LOAD_Ready_Out, CC_WB_LOAD_Timeout_Out
    );

    modport slave (
        input  CC_WB_LOAD_Start_In, CC_WB_LOAD_RD_In, CC_WB_LOAD_ALU_data_InBus,
               CC_WB_LOAD_Address_InBus, CC_WB_LOAD_MemReady_In,
               CC_WB_LOAD_Memory_data_InBus, CC_WB_LOAD_ErrorClear_In,
        output CC_WB_LOAD_data_OutBus, CC_WB_LOAD_Load_OutBus,
               CC_WB_LOAD_Ready_Out, CC_WB_LOAD_Timeout_Out
    );
endinterface

// File: rtl/cc_wb_load_ctrl.sv
// Writeback/load controller for the datapath register file.
// Registers the writeback source (ALU result or memory read data) and pulses
// exactly one active-low register load enable per accepted request. Memory
// requests wait for MemReady with a timeout; a timeout sets a sticky flag and
// aborts the request without a load pulse.
// Ports:
//   CC_WB_LOAD_CLOCK_50     system clock, rising edge
//   CC_WB_LOAD_RESET_InHigh asynchronous active-high reset
//   bus                     cc_wb_load_ctrl_if slave (handshake, data, enables)
module cc_wb_load_ctrl #(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DATAWIDTH_MIR_DIRECTION = 6,
    parameter int NUM_REGS                = 14,
    parameter int REG_BASE                = 2,
    parameter int MEM_TIMEOUT             = 15
) (
    input logic              CC_WB_LOAD_CLOCK_50,
    input logic              CC_WB_LOAD_RESET_InHigh,
    cc_wb_load_ctrl_if.slave bus
);
    localparam int AW   = DATAWIDTH_MIR_DIRECTION;
    // One extra bit so addresses below REG_BASE cannot wrap into range.
    localparam int OFFW = DATAWIDTH_MIR_DIRECTION + 1;
    localparam logic [OFFW-1:0] BASE_W = OFFW'(REG_BASE);
    localparam logic [OFFW-1:0] NREG_W = OFFW'(NUM_REGS);
    localparam logic [7:0]      LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

    state_t                   state;
    logic [DATAWIDTH_BUS-1:0] dataReg;
    logic [NUM_REGS-1:0]      loadReg;
    logic                     readyReg;
    logic                     timeoutReg;
    logic [7:0]               waitCnt;
    logic [AW-1:0]            addrReg;

    // Active-low one-cold enable for an address; all ones when out of range.
    function automatic logic [NUM_REGS-1:0] decodeLoad(input logic [AW-1:0] addr);
        logic [OFFW-1:0] addrExt;
        logic [OFFW-1:0] offset;
        decodeLoad = '1;
        addrExt    = {1'b0, addr};
        offset     = addrExt - BASE_W;
        if (addrExt >= BASE_W && offset < NREG_W) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (offset == OFFW'(i)) decodeLoad[i] = 1'b0;
            end
        end
    endfunction

    // Load enables are registered alongside the transition into WRITE, so
    // the pulse lines up with the WRITE state and carries no decode glitches.
    always_ff @(posedge CC_WB_LOAD_CLOCK_50 or posedge CC_WB_LOAD_RESET_InHigh) begin
        if (CC_WB_LOAD_RESET_InHigh) begin
            state      <= IDLE;
            dataReg    <= '0;
            loadReg    <= '1;
            readyReg   <= 1'b1;
            timeoutReg <= 1'b0;
            waitCnt    <= '0;
            addrReg    <= '0;
        end else begin
            loadReg  <= '1;
            readyReg <= 1'b1;
            // A timeout raised below in the same cycle overrides this clear.
            if (bus.CC_WB_LOAD_ErrorClear_In) timeoutReg <= 1'b0;
            case (state)
                IDLE, WRITE: begin
                    if (bus.CC_WB_LOAD_Start_In) begin
                        addrReg <= bus.CC_WB_LOAD_Address_InBus;
                        if (bus.CC_WB_LOAD_RD_In) begin
                            waitCnt  <= '0;
                            state    <= WAIT_MEM;
                            readyReg <= 1'b0;
                        end else begin
                            dataReg <= bus.CC_WB_LOAD_ALU_data_InBus;
                            loadReg <= decodeLoad(bus.CC_WB_LOAD_Address_InBus);
                            state   <= WRITE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_MEM: begin
                    if (bus.CC_WB_LOAD_MemReady_In) begin
                        dataReg <= bus.CC_WB_LOAD_Memory_data_InBus;
                        loadReg <= decodeLoad(addrReg);
                        state   <= WRITE;
                    end else if (waitCnt == LAST_WAIT) begin
                        timeoutReg <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        waitCnt  <= waitCnt + 8'd1;
                        readyReg <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.CC_WB_LOAD_data_OutBus = dataReg;
    assign bus.CC_WB_LOAD_Load_OutBus = loadReg;
    assign bus.CC_WB_LOAD_Ready_Out   = readyReg;
    assign bus.CC_WB_LOAD_Timeout_Out = timeoutReg;
endmodule

// File: tb/tb_cc_wb_load_ctrl.sv
// Self-checking bench for cc_wb_load_ctrl: a vector table for single-cycle
// ALU requests, plus hand-written memory, timeout and reset sequences.
module tb_cc_wb_load_ctrl;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 14;
    localparam logic [NR-1:0] ONES = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cc_wb_load_ctrl_if #(.DATAWIDTH_BUS(DW), .DATAWIDTH_MIR_DIRECTION(AW), .NUM_REGS(NR)) bus ();

    cc_wb_load_ctrl #(
        .DATAWIDTH_BUS(DW), .DATAWIDTH_MIR_DIRECTION(AW), .NUM_REGS(NR),
        .REG_BASE(2), .MEM_TIMEOUT(15)
    ) dut (
        .CC_WB_LOAD_CLOCK_50    (clk),
        .CC_WB_LOAD_RESET_InHigh(rst),
        .bus                    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          start;
        logic          rd;
        logic [DW-1:0] alu;
        logic [AW-1:0] addr;
        logic          memReady;
        logic [DW-1:0] mem;
        logic          errClr;
        logic [DW-1:0] expData;
        logic [NR-1:0] expLoad;
        logic          expReady;
        logic          expTimeout;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chkAll(input string name, input logic [DW-1:0] d, input logic [NR-1:0] l,
                          input logic r, input logic t);
        chk({name, ".data"},    bus.CC_WB_LOAD_data_OutBus, d);
        chk({name, ".load"},    DW'(bus.CC_WB_LOAD_Load_OutBus), DW'(l));
        chk({name, ".ready"},   DW'(bus.CC_WB_LOAD_Ready_Out), DW'(r));
        chk({name, ".timeout"}, DW'(bus.CC_WB_LOAD_Timeout_Out), DW'(t));
    endtask

    task automatic drive(input logic s, input logic r, input logic [DW-1:0] a,
                         input logic [AW-1:0] ad, input logic mr, input logic [DW-1:0] m,
                         input logic ec);
        bus.CC_WB_LOAD_Start_In          = s;
        bus.CC_WB_LOAD_RD_In             = r;
        bus.CC_WB_LOAD_ALU_data_InBus    = a;
        bus.CC_WB_LOAD_Address_InBus     = ad;
        bus.CC_WB_LOAD_MemReady_In       = mr;
        bus.CC_WB_LOAD_Memory_data_InBus = m;
        bus.CC_WB_LOAD_ErrorClear_In     = ec;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        name         st   rd   alu            addr  mr   mem            ec   expData        expLoad                 rdy  to
        vecs[0]  = '{"alu6",    1, 0, 32'hDEADBEEF, 6'd6,  0, 32'h0,        0, 32'hDEADBEEF, 14'b11111111101111, 1, 0};
        vecs[1]  = '{"idle1",   0, 0, 32'h0,        6'd0,  0, 32'h0,        0, 32'hDEADBEEF, 14'b11111111111111, 1, 0};
        vecs[2]  = '{"b2b3",    1, 0, 32'h1,        6'd3,  0, 32'h0,        0, 32'h1,        14'b11111111111101, 1, 0};
        vecs[3]  = '{"b2b4",    1, 0, 32'h2,        6'd4,  0, 32'h0,        0, 32'h2,        14'b11111111111011, 1, 0};
        vecs[4]  = '{"idle2",   0, 0, 32'h0,        6'd0,  0, 32'h0,        0, 32'h2,        14'b11111111111111, 1, 0};
        vecs[5]  = '{"addr0",   1, 0, 32'hA0,       6'd0,  0, 32'h0,        0, 32'hA0,       14'b11111111111111, 1, 0};
        vecs[6]  = '{"addr1",   1, 0, 32'hA1,       6'd1,  0, 32'h0,        0, 32'hA1,       14'b11111111111111, 1, 0};
        vecs[7]  = '{"addr16",  1, 0, 32'hA16,      6'd16, 0, 32'h0,        0, 32'hA16,      14'b11111111111111, 1, 0};
        vecs[8]  = '{"addr2",   1, 0, 32'h22,       6'd2,  0, 32'h0,        0, 32'h22,       14'b11111111111110, 1, 0};
        vecs[9]  = '{"addr15",  1, 0, 32'h33,       6'd15, 0, 32'h0,        0, 32'h33,       14'b01111111111111, 1, 0};
        vecs[10] = '{"addr63",  1, 0, 32'h44,       6'd63, 0, 32'h0,        0, 32'h44,       14'b11111111111111, 1, 0};
        vecs[11] = '{"memIgn",  0, 0, 32'h0,        6'd0,  1, 32'hBAD,      0, 32'h44,       14'b11111111111111, 1, 0};
        vecs[12] = '{"clrIdle", 0, 0, 32'h0,        6'd0,  0, 32'h0,        1, 32'h44,       14'b11111111111111, 1, 0};

        idle();
        step();
        chkAll("inReset", 32'h0, ONES, 1'b1, 1'b0);
        #4 rst = 1'b0;
        step();
        chkAll("afterReset", 32'h0, ONES, 1'b1, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].rd, vecs[i].alu, vecs[i].addr,
                  vecs[i].memReady, vecs[i].mem, vecs[i].errClr);
            step();
            chkAll(vecs[i].name, vecs[i].expData, vecs[i].expLoad, vecs[i].expReady, vecs[i].expTimeout);
        end

        // Memory read to addr 15, ready on the third wait cycle; a start during
        // the wait must be ignored and not queued.
        drive(1'b1, 1'b1, 32'hFFFF, 6'd15, 1'b0, 32'h0, 1'b0);
        step();
        chkAll("memW1", 32'h44, ONES, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'h55, 6'd3, 1'b0, 32'h0, 1'b0);
        step();
        chkAll("memW2", 32'h44, ONES, 1'b0, 1'b0);
        idle();
        step();
        chkAll("memW3", 32'h44, ONES, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 6'd0, 1'b1, 32'h12345678, 1'b0);
        step();
        chkAll("memPulse", 32'h12345678, 14'b01111111111111, 1'b1, 1'b0);
        idle();
        step();
        chkAll("memAfter", 32'h12345678, ONES, 1'b1, 1'b0);
        step();
        chkAll("noQueued", 32'h12345678, ONES, 1'b1, 1'b0);

        // Timeout: 15 wait cycles with no ready.
        drive(1'b1, 1'b1, 32'h0, 6'd2, 1'b0, 32'h0, 1'b0);
        step();
        idle();
        for (int n = 1; n <= 14; n++) begin
            step();
            chk("toWaitReady", DW'(bus.CC_WB_LOAD_Ready_Out), 32'd0);
            chk("toWaitLoad", DW'(bus.CC_WB_LOAD_Load_OutBus), DW'(ONES));
        end
        chk("toNotYet", DW'(bus.CC_WB_LOAD_Timeout_Out), 32'd0);
        step();
        chkAll("timeout", 32'h12345678, ONES, 1'b1, 1'b1);
        step();
        chkAll("toSticky", 32'h12345678, ONES, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b1);
        step();
        chkAll("toClear", 32'h12345678, ONES, 1'b1, 1'b0);

        // Ready on the last allowed wait cycle is still accepted.
        drive(1'b1, 1'b1, 32'h0, 6'd5, 1'b0, 32'h0, 1'b0);
        step();
        idle();
        repeat (14) step();
        drive(1'b0, 1'b0, 32'h0, 6'd0, 1'b1, 32'hCAFE, 1'b0);
        step();
        chkAll("lastReady", 32'hCAFE, 14'b11111111110111, 1'b1, 1'b0);

        // New timeout while ErrorClear is held: set wins.
        drive(1'b1, 1'b1, 32'h0, 6'd7, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b1);
        repeat (15) step();
        chkAll("setWins", 32'hCAFE, ONES, 1'b1, 1'b1);

        // Asynchronous reset in the middle of WAIT_MEM.
        drive(1'b1, 1'b1, 32'h0, 6'd7, 1'b0, 32'h0, 1'b0);
        step();
        chk("preRstWait", DW'(bus.CC_WB_LOAD_Ready_Out), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 6'd0, 1'b1, 32'h9999, 1'b0);
        #2 rst = 1'b1;
        #1 chkAll("rstWait", 32'h0, ONES, 1'b1, 1'b0);
        #1 rst = 1'b0;
        step();
        chkAll("rstWaitRel1", 32'h0, ONES, 1'b1, 1'b0);
        step();
        chkAll("rstWaitRel2", 32'h0, ONES, 1'b1, 1'b0);

        // Asynchronous reset during a WRITE pulse.
        drive(1'b1, 1'b0, 32'h77, 6'd6, 1'b0, 32'h0, 1'b0);
        step();
        chkAll("preRstWrite", 32'h77, 14'b11111111101111, 1'b1, 1'b0);
        idle();
        #2 rst = 1'b1;
        #1 chkAll("rstWrite", 32'h0, ONES, 1'b1, 1'b0);
        #1 rst = 1'b0;
        step();
        chkAll("rstWriteRel", 32'h0, ONES, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cc_wb_load_ctrl.md
Name: cc_wb_load_ctrl

Overview:
Parametrised, sequential writeback/load controller for the datapath register file. It registers the writeback source (ALU result or main-memory read data) and decodes the destination address into active-low per-register load enables. It waits on a memory-ready handshake with a timeout and pulses exactly one load enable per accepted request. It sits between the ALU/main memory and the register bank, driven by the microsequencer.

Parameters:
DATAWIDTH_BUS, 32, width of data buses
DATAWIDTH_MIR_DIRECTION, 6, width of destination address field
NUM_REGS, 14, number of writable registers (width of load-enable bus)
REG_BASE, 2, address mapped to load-enable bit 0
MEM_TIMEOUT, 15, max WAIT_MEM cycles without ready before abort (1..255)

Ports:
CC_WB_LOAD_CLOCK_50  input  1  system clock, rising edge
CC_WB_LOAD_RESET_InHigh  input  1  asynchronous active-high reset
CC_WB_LOAD_Start_In  input  1  request valid, sampled only when Ready_Out=1
CC_WB_LOAD_RD_In  input  1  source select at start: 1=memory, 0=ALU
CC_WB_LOAD_ALU_data_InBus  input  DATAWIDTH_BUS  ALU result
CC_WB_LOAD_Address_InBus  input  DATAWIDTH_MIR_DIRECTION  destination register address
CC_WB_LOAD_MemReady_In  input  1  memory data valid this cycle
CC_WB_LOAD_Memory_data_InBus  input  DATAWIDTH_BUS  memory read data
CC_WB_LOAD_ErrorClear_In  input  1  synchronous clear of sticky error flag
CC_WB_LOAD_data_OutBus  output  DATAWIDTH_BUS  registered writeback data
CC_WB_LOAD_Load_OutBus  output  NUM_REGS  active-low one-cold load enables
CC_WB_LOAD_Ready_Out  output  1  request can be accepted this cycle
CC_WB_LOAD_Timeout_Out  output  1  sticky memory-timeout error flag

Behaviour:
- Operation is synchronous to the rising edge of CC_WB_LOAD_CLOCK_50. Reset is asynchronous and active-high.
- Reset values: state=IDLE, data_OutBus=0, Load_OutBus=all ones, Timeout_Out=0, wait counter=0, captured address=0. Ready_Out=1 after reset.
- FSM has three states: IDLE, WAIT_MEM, WRITE. Ready_Out=1 in IDLE and WRITE, 0 in WAIT_MEM.
- IDLE/WRITE, Start=1, RD=0: capture ALU data into data_OutBus and capture the address. Next state is WRITE. Latency is 1 cycle from start to load pulse.
- IDLE/WRITE, Start=1, RD=1: capture the address, clear the counter, next state WAIT_MEM. data_OutBus holds its previous value.
- IDLE/WRITE, Start=0: next state IDLE.
- WAIT_MEM, MemReady=1: capture memory data into data_OutBus, next state WRITE. The earliest load pulse is 2 cycles after start.
- WAIT_MEM, MemReady=0: counter increments. When counter reaches MEM_TIMEOUT-1 with no ready in that cycle, set Timeout_Out=1 and go to IDLE. No load pulse is issued and data_OutBus is unchanged.
- MemReady is ignored outside WAIT_MEM. Start is ignored in WAIT_MEM and is not queued.
- WRITE: Load_OutBus bit (addr-REG_BASE)=0 and all other bits=1, for exactly one cycle.
  - Valid range is REG_BASE <= addr <= REG_BASE+NUM_REGS-1.
  - Addresses outside the range give all ones (silent discard) but still complete the transaction.
  - In every other state Load_OutBus is all ones.
- Back-to-back requests: a start accepted in WRITE overwrites the data/address capture regs at the end of that cycle. The current pulse uses the values already registered, so data_OutBus stays valid throughout its pulse cycle.
- Load_OutBus is registered, decoded from the next-state address, so it is glitch-free.
- Timeout_Out stays set until reset or ErrorClear=1. If ErrorClear and a new timeout occur in the same cycle, set wins.
- Reset mid-WAIT_MEM or mid-WRITE: return to IDLE immediately. Any pending pulse is suppressed and all outputs take reset values.
- Arithmetic: the address offset is computed at DATAWIDTH_MIR_DIRECTION+1 bits so values below REG_BASE do not wrap into range. The counter is 8 bits.

Test Plan:
- Reset, then Start=1, RD=0, ALU=0xDEADBEEF, addr=6 for 1 cycle -> next cycle data_OutBus=0xDEADBEEF and Load_OutBus=14'b11111111101111 for 1 cycle, then all ones; Ready_Out stays 1.
- Start, RD=1, addr=15, MemReady asserted 3 cycles later with data 0x12345678 -> Ready_Out=0 for 3 cycles; then data_OutBus=0x12345678 and Load_OutBus=14'b01111111111111 for 1 cycle.
- RD=1, addr=2, MemReady never asserted -> after 15 WAIT_MEM cycles Timeout_Out=1, state IDLE, no load pulse. ErrorClear=1 for 1 cycle -> Timeout_Out=0.
- Back-to-back ALU requests to addr 3 (0x1) and addr 4 (0x2) on consecutive cycles -> consecutive pulses 14'b...1101 with data 0x1, then 14'b...1011 with data 0x2.
- Address 0, 1, and 16 with RD=0 -> data_OutBus updates, Load_OutBus stays all ones, Ready_Out=1 next cycle.
- Assert RESET_InHigh asynchronously mid-WAIT_MEM, and again during a WRITE pulse -> outputs go to reset values immediately; no pulse after reset is released.
